nios_system_button_pio_in: RTL

Avalon-MM slave input port for the player's push-buttons and switches. It is the read-side counterpart to the write-only output PIOs on the same Nios II system bus. The block synchronises and debounces each input bit and latches rising edges into an edge-capture register. It raises a maskable interrupt so software can poll or take an IRQ instead of sampling the raw pins.

---
 rtl/nios_system_button_pio_in.sv | 105 ++++++++++
 1 files changed

// File: rtl/nios_system_button_pio_in.sv
// Avalon-MM input PIO: synchronises and debounces button/switch inputs, latches
// rising edges into a write-1-to-clear capture register and raises a maskable irq.
module nios_system_button_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] stable_r;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] edgecap_r;
    logic [WIDTH-1:0] irqmask_r;
    logic [CW-1:0]    cnt_r [WIDTH];

    logic             wr_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] stable_nxt_s;
    logic [CW-1:0]    cnt_nxt_s [WIDTH];
    logic             unused_ok_s;

    assign wr_s        = chipselect & ~write_n;
    assign rise_s      = stable_r & ~prev_r;
    assign irq         = |(edgecap_r & irqmask_r);
    assign unused_ok_s = ^writedata;

    // Per-bit debounce: stable follows sync2 only after DEBOUNCE_CYCLES straight mismatches.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            stable_nxt_s[i] = stable_r[i];
            cnt_nxt_s[i]    = {CW{1'b0}};
            if (sync2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = {CW{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                stable_nxt_s[i] = sync2_r[i];
                cnt_nxt_s[i]    = {CW{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CW'(1);
            end
        end
    end

    // Write-1-to-clear mask for the edge-capture register.
    always_comb begin
        if (wr_s && (address == 2'd3)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
    end

    // All state: synchroniser, debounce, edge detect, capture and mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r   <= {WIDTH{1'b0}};
            sync2_r   <= {WIDTH{1'b0}};
            stable_r  <= {WIDTH{1'b0}};
            prev_r    <= {WIDTH{1'b0}};
            edgecap_r <= {WIDTH{1'b0}};
            irqmask_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            sync1_r  <= in_port;
            sync2_r  <= sync1_r;
            stable_r <= stable_nxt_s;
            prev_r   <= stable_r;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            // A new rise on the same edge as its clear keeps the bit set.
            edgecap_r <= (edgecap_r & ~clr_s) | rise_s;
            if (wr_s && (address == 2'd2)) begin
                irqmask_r <= writedata[WIDTH-1:0];
            end
        end
    end

    // Zero-wait-state read mux, zero-extended.
    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable_r;
            2'd2:    readdata[WIDTH-1:0] = irqmask_r;
            2'd3:    readdata[WIDTH-1:0] = edgecap_r;
            default: readdata = 32'd0;
        endcase
    end

endmodule
